// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the 4x4 register-file SRAM access arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4,
    VERIFY = 3'd5
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/sram4x4_access_arbiter_if.sv
// Requester and SRAM-side signals of the arbiter; verr exists only with SRAM_WRITE_VERIFY_EN.
// Handshake: a requester holds reqN with stable fields until gntN pulses; the fields are
// captured on the edge that raises gntN, and doneN pulses once the access has completed.
interface sram4x4_access_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_din;
  logic              sram_we;
  logic [DATA_W-1:0] sram_dout;
  logic              busy;
`ifdef SRAM_WRITE_VERIFY_EN
  logic              verr;
`endif

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, sram_dout,
    output gnt0, gnt1, done0, done1, rdata, sram_addr, sram_din, sram_we, busy
`ifdef SRAM_WRITE_VERIFY_EN
    , output verr
`endif
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, sram_dout,
    input  gnt0, gnt1, done0, done1, rdata, sram_addr, sram_din, sram_we, busy
`ifdef SRAM_WRITE_VERIFY_EN
    , input verr
`endif
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on contention the requester that did not win last time wins.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  req_id_t last_winner,
  output req_id_t winner,
  output logic    valid
);

  always_comb begin
    valid  = req0 | req1;
    winner = REQ0;
    if (req0 && req1) begin
      winner = (last_winner == REQ0) ? REQ1 : REQ0;
    end else if (req1) begin
      winner = REQ1;
    end
  end

endmodule

// File: rtl/sram4x4_access_arbiter.sv
// Round-robin sequencer sharing one 4x4 SRAM between two requesters.
// Optional write read-back check and sticky verr flag: define SRAM_WRITE_VERIFY_EN.
module sram4x4_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)
(
  input  logic                           CLK,
  input  logic                           RST,
  sram4x4_access_arbiter_if.slave        bus,
  output state_t                         state_dbg
);

  state_t            state;
  state_t            state_n;
  req_id_t           pick;
  logic              pick_valid;
  req_id_t           winner_q;
  req_id_t           last_winner;
  logic              op_we;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0] sram_din_q;
  logic [DATA_W-1:0] rdata_q;
  logic              gnt0_q;
  logic              gnt1_q;
  logic              done0_q;
  logic              done1_q;
  logic              sram_we_q;
  logic              busy_q;

  rr_arb2 u_rr_arb2 (
    .req0        (bus.req0),
    .req1        (bus.req1),
    .last_winner (last_winner),
    .winner      (pick),
    .valid       (pick_valid)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_valid) state_n = SETUP;
      SETUP:   state_n = op_we ? STROBE : SAMPLE;
`ifdef SRAM_WRITE_VERIFY_EN
      STROBE:  state_n = VERIFY;
      VERIFY:  state_n = DONE;
`else
      STROBE:  state_n = DONE;
`endif
      SAMPLE:  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Every output is a register loaded from the next state, so pulses line up with states.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      winner_q    <= REQ0;
      last_winner <= REQ1;
      op_we       <= 1'b0;
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      rdata_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      sram_we_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state     <= state_n;
      gnt0_q    <= (state == IDLE) && pick_valid && (pick == REQ0);
      gnt1_q    <= (state == IDLE) && pick_valid && (pick == REQ1);
      done0_q   <= (state_n == DONE) && (winner_q == REQ0);
      done1_q   <= (state_n == DONE) && (winner_q == REQ1);
      sram_we_q <= (state_n == STROBE);
      busy_q    <= (state_n != IDLE);
      if ((state == IDLE) && pick_valid) begin
        winner_q    <= pick;
        op_we       <= (pick == REQ1) ? bus.we1    : bus.we0;
        sram_addr_q <= (pick == REQ1) ? bus.addr1  : bus.addr0;
        sram_din_q  <= (pick == REQ1) ? bus.wdata1 : bus.wdata0;
      end
      if (state == SAMPLE) rdata_q <= bus.sram_dout;
      if (state == DONE) last_winner <= winner_q;
    end
  end

`ifdef SRAM_WRITE_VERIFY_EN
  logic verr_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      verr_q <= 1'b0;
    end else if ((state == VERIFY) && (bus.sram_dout != sram_din_q)) begin
      verr_q <= 1'b1;
    end
  end

  assign bus.verr = verr_q;
`endif

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.rdata     = rdata_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_din  = sram_din_q;
  assign bus.sram_we   = sram_we_q;
  assign bus.busy      = busy_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_sram4x4_access_arbiter.sv
// Directed bench for sram4x4_access_arbiter with a behavioural 4x4 SRAM; covers SRAM_WRITE_VERIFY_EN when defined.
module tb_sram4x4_access_arbiter;
  import sram_arb_pkg::*;

  logic   CLK;
  logic   RST;
  state_t state_dbg;
  int     vectors;
  int     miscompares;
  logic   stuck_en;
  logic [3:0] mem [0:3];

  sram4x4_access_arbiter_if bus ();

  sram4x4_access_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // SRAM model: synchronous write, asynchronous read, optional bit0 stuck-at-0
  always @(posedge CLK) begin
    if (bus.sram_we) mem[bus.sram_addr] <= stuck_en ? (bus.sram_din & 4'hE) : bus.sram_din;
  end
  assign bus.sram_dout = mem[bus.sram_addr];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    stuck_en    = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 4'h0;
    RST = 1'b1;
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    step();
    step();
    check("rst_state", state_dbg, IDLE);
    check("rst_busy", bus.busy, 0);
    check("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
    check("rst_done", {bus.done0, bus.done1}, 0);
    check("rst_we", bus.sram_we, 0);
    check("rst_addr", bus.sram_addr, 0);
    check("rst_din", bus.sram_din, 0);
    check("rst_rdata", bus.rdata, 0);
`ifdef SRAM_WRITE_VERIFY_EN
    check("rst_verr", bus.verr, 0);
`endif
    RST = 1'b0;

    // Write 0xA to address 2 from requester 0
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 2; bus.wdata0 = 4'hA;
    step();
    check("wr_gnt0", bus.gnt0, 1);
    check("wr_gnt1", bus.gnt1, 0);
    check("wr_busy", bus.busy, 1);
    check("wr_setup_addr", bus.sram_addr, 2);
    check("wr_setup_din", bus.sram_din, 4'hA);
    check("wr_setup_we", bus.sram_we, 0);
    bus.req0 = 0;
    step();
    check("wr_strobe_we", bus.sram_we, 1);
    check("wr_strobe_addr", bus.sram_addr, 2);
    check("wr_strobe_din", bus.sram_din, 4'hA);
    check("wr_strobe_gnt0", bus.gnt0, 0);
`ifdef SRAM_WRITE_VERIFY_EN
    step();
    check("wr_verify_we", bus.sram_we, 0);
    check("wr_verify_done", bus.done0, 0);
`endif
    step();
    check("wr_done0", bus.done0, 1);
    check("wr_done_we", bus.sram_we, 0);
    check("wr_hold_addr", bus.sram_addr, 2);
    check("wr_hold_din", bus.sram_din, 4'hA);
    step();
    check("wr_idle_done", bus.done0, 0);
    check("wr_idle_busy", bus.busy, 0);

    // Read address 2 from requester 1
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 2;
    step();
    check("rd_gnt1", bus.gnt1, 1);
    check("rd_gnt0", bus.gnt0, 0);
    check("rd_addr", bus.sram_addr, 2);
    bus.req1 = 0;
    step();
    check("rd_sample_we", bus.sram_we, 0);
    check("rd_sample_done", bus.done1, 0);
    step();
    check("rd_done1", bus.done1, 1);
    check("rd_done_we", bus.sram_we, 0);
    check("rd_rdata", bus.rdata, 4'hA);
    step();
    check("rd_idle_busy", bus.busy, 0);
    check("rd_idle_done", bus.done1, 0);

    // Both requesters held: grants alternate 0,1,0,1 from reset
    RST = 1'b1;
    step();
    RST = 1'b0;
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 1; bus.wdata0 = 4'h3;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 0; bus.wdata1 = 4'hC;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_gnt0", bus.gnt0, (k % 2 == 0) ? 1 : 0);
      check("rr_gnt1", bus.gnt1, (k % 2 == 1) ? 1 : 0);
      step();
      check("rr_we", bus.sram_we, 1);
      check("rr_addr", bus.sram_addr, (k % 2 == 0) ? 1 : 0);
`ifdef SRAM_WRITE_VERIFY_EN
      step();
`endif
      step();
      check("rr_done0", bus.done0, (k % 2 == 0) ? 1 : 0);
      check("rr_done1", bus.done1, (k % 2 == 1) ? 1 : 0);
      step();
      check("rr_idle_busy", bus.busy, 0);
      if (k == 3) begin
        bus.req0 = 0;
        bus.req1 = 0;
      end
    end

    // Reset during STROBE of write addr 3 data 5
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 3; bus.wdata0 = 4'h5;
    step();
    bus.req0 = 0;
    step();
    check("abort_pre_we", bus.sram_we, 1);
    RST = 1'b1;
    #1;
    check("abort_we", bus.sram_we, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_addr", bus.sram_addr, 0);
    check("abort_din", bus.sram_din, 0);
    check("abort_gnt", {bus.gnt0, bus.gnt1}, 0);
    #2;
    RST = 1'b0;
    step();
    check("abort_no_done", {bus.done0, bus.done1}, 0);
    check("abort_idle", bus.busy, 0);
    check("abort_mem3", mem[3], 0);

    // Requester 0 read; requester 1 raised during its SETUP is held off until IDLE
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 1;
    step();
    check("late_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 0;
    step();
    check("late_sample_gnt1", bus.gnt1, 0);
    check("late_sample_we", bus.sram_we, 0);
    step();
    check("late_done0", bus.done0, 1);
    check("late_rdata0", bus.rdata, 4'h3);
    check("late_done_gnt1", bus.gnt1, 0);
    step();
    check("late_idle_busy", bus.busy, 0);
    check("late_idle_gnt1", bus.gnt1, 0);
    step();
    check("late_gnt1", bus.gnt1, 1);
    check("late_addr1", bus.sram_addr, 0);
    bus.req1 = 0;
    step();
    check("late_we1", bus.sram_we, 0);
    step();
    check("late_done1", bus.done1, 1);
    check("late_rdata1", bus.rdata, 4'hC);
    step();
    check("late_end_busy", bus.busy, 0);

`ifdef SRAM_WRITE_VERIFY_EN
    // Bit0 stuck-at-0 makes a write of 0x7 read back as 0x6
    stuck_en = 1'b1;
    check("vfy_verr_pre", bus.verr, 0);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 2; bus.wdata0 = 4'h7;
    step();
    bus.req0 = 0;
    step();
    check("vfy_strobe_we", bus.sram_we, 1);
    step();
    check("vfy_verify_verr", bus.verr, 0);
    step();
    check("vfy_done0", bus.done0, 1);
    check("vfy_verr_set", bus.verr, 1);
    step();
    step();
    check("vfy_verr_sticky", bus.verr, 1);
    RST = 1'b1;
    #1;
    check("vfy_verr_rst", bus.verr, 0);
    RST = 1'b0;
    stuck_en = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
